// File: rtl/muldiv_sched.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage: fixed-latency multiply,
// 32-step restoring divide, pipeline stall until HI/LO is written.
module muldiv_sched #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        is_div_i,
  input  logic        signed_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  input  logic        stall_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_next;
  logic [5:0]  cnt;
  logic [31:0] quo, rem, dvs, hi, lo;
  logic [63:0] product;
  logic        qneg, rneg;

  logic        start, mul_last, div_last;
  logic [31:0] a_abs, b_abs;
  logic [63:0] prod_s, prod_u;
  logic [32:0] trial, diff;
  logic        take;
  logic [31:0] rem_next, quo_next;

  assign start    = (state == IDLE) & valid_i & ~flush_i;
  assign mul_last = (state == MUL) & (cnt == 6'(MUL_LAT - 1));
  assign div_last = (state == DIV) & (cnt == 6'd31);

  assign a_abs = (signed_i & src_a_i[31]) ? (~src_a_i + 32'd1) : src_a_i;
  assign b_abs = (signed_i & src_b_i[31]) ? (~src_b_i + 32'd1) : src_b_i;

  assign prod_s = $signed({{32{src_a_i[31]}}, src_a_i}) * $signed({{32{src_b_i[31]}}, src_b_i});
  assign prod_u = {32'd0, src_a_i} * {32'd0, src_b_i};

  // Remainder stays below the divisor, so the difference never needs bit 32 when the
  // subtract is taken; bit 32 therefore doubles as the borrow.
  assign trial    = {rem, quo[31]};
  assign diff     = trial - {1'b0, dvs};
  assign take     = ~diff[32];
  assign rem_next = take ? diff[31:0] : trial[31:0];
  assign quo_next = {quo[30:0], take};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    done_o     = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (!is_div_i)            state_next = MUL;
        else if (src_b_i != '0)   state_next = DIV;
        else                      state_next = DONE;
      end
      MUL:  if (mul_last) state_next = DONE;
      DIV:  if (div_last) state_next = DONE;
      DONE: if (!stall_i) begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush_i) begin
      state_next = IDLE;
      done_o     = 1'b0;
    end
  end

  assign hilo_we_o = done_o;
  assign busy_o    = (state != IDLE);
  assign stall_o   = valid_i & ~flush_i & ~((state == DONE) & ~stall_i);
  assign hi_o      = hi;
  assign lo_o      = lo;

  // A flushed cycle leaves every register untouched so a cancelled op cannot leak into HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      hi      <= '0;
      lo      <= '0;
      product <= '0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
    end else if (!flush_i) begin
      case (state)
        IDLE: if (valid_i) begin
          cnt <= '0;
          if (is_div_i) begin
            quo  <= a_abs;
            dvs  <= b_abs;
            rem  <= '0;
            qneg <= signed_i & (src_a_i[31] ^ src_b_i[31]);
            rneg <= signed_i & src_a_i[31];
            if (src_b_i == '0) begin
              lo <= 32'hFFFF_FFFF;
              hi <= src_a_i;
            end
          end else begin
            product <= signed_i ? prod_s : prod_u;
          end
        end
        MUL: begin
          cnt <= cnt + 6'd1;
          if (mul_last) begin
            hi <= product[63:32];
            lo <= product[31:0];
          end
        end
        DIV: begin
          cnt <= cnt + 6'd1;
          rem <= rem_next;
          quo <= quo_next;
          if (div_last) begin
            lo <= qneg ? (~quo_next + 32'd1) : quo_next;
            hi <= rneg ? (~rem_next + 32'd1) : rem_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: multiply/divide results, stall timing, flush, reset and DONE stalls.
module tb_muldiv_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, is_div_i, signed_i, flush_i, stall_i;
  logic [31:0] src_a_i, src_b_i;
  logic        stall_o, busy_o, done_o, hilo_we_o;
  logic [31:0] hi_o, lo_o;

  int checks   = 0;
  int failures = 0;

  muldiv_sched #(.MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .is_div_i(is_div_i), .signed_i(signed_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i), .stall_i(stall_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .hilo_we_o(hilo_we_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic div, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    valid_i  = 1'b1;
    is_div_i = div;
    signed_i = sgn;
    src_a_i  = a;
    src_b_i  = b;
  endtask

  // Starts at a negedge, runs one op to its write, ends in the following IDLE cycle.
  task automatic runOp(input string tag, input logic div, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b, input int expStall,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    int  stalls = 0;
    int  wes    = 0;
    int  cyc    = 0;
    bit  got    = 0;
    applyStimulus(div, sgn, a, b);
    while (!got && cyc < 80) begin
      #1;
      if (stall_o)   stalls++;
      if (hilo_we_o) wes++;
      if (done_o) begin
        got = 1;
        checkOutput({tag, " hi"}, hi_o, expHi);
        checkOutput({tag, " lo"}, lo_o, expLo);
      end
      @(negedge clk);
      cyc++;
    end
    if (!got) checkOutput({tag, " timeout"}, 32'd0, 32'd1);
    valid_i = 1'b0;
    #1;
    if (hilo_we_o) wes++;
    checkOutput({tag, " stalls"}, stalls, expStall);
    checkOutput({tag, " writes"}, wes, 32'd1);
    checkOutput({tag, " idle"}, busy_o, 32'd0);
  endtask

  initial begin
    int wes;
    rst = 1'b1; valid_i = 1'b0; is_div_i = 1'b0; signed_i = 1'b0;
    src_a_i = '0; src_b_i = '0; flush_i = 1'b0; stall_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst busy",  busy_o,    32'd0);
    checkOutput("rst done",  done_o,    32'd0);
    checkOutput("rst we",    hilo_we_o, 32'd0);
    checkOutput("rst stall", stall_o,   32'd0);
    checkOutput("rst hi",    hi_o,      32'd0);
    checkOutput("rst lo",    lo_o,      32'd0);
    rst = 1'b0;
    @(negedge clk);

    runOp("multu max", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 32'hFFFFFFFE, 32'h00000001);
    runOp("mult -3*5", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5,        3, 32'hFFFFFFFF, 32'hFFFFFFF1);
    runOp("multu shf", 1'b0, 1'b0, 32'h12345678, 32'h100,      3, 32'h00000012, 32'h34567800);
    runOp("mult min2", 1'b0, 1'b1, 32'h80000000, 32'h80000000, 3, 32'h40000000, 32'h00000000);
    runOp("div -7/2",  1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,       33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("divu 7/2",  1'b1, 1'b0, 32'd7,        32'd2,       33, 32'd1,        32'd3);
    runOp("div ovf",   1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF,33, 32'd0,        32'h80000000);
    runOp("div 100/-7",1'b1, 1'b1, 32'd100,      32'hFFFFFFF9,33, 32'd2,        32'hFFFFFFF2);
    runOp("div -8/-3", 1'b1, 1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD,33, 32'hFFFFFFFE, 32'd2);
    runOp("divu big",  1'b1, 1'b0, 32'hFFFFFFFF, 32'h10,      33, 32'h0000000F, 32'h0FFFFFFF);
    runOp("divu 5/0",  1'b1, 1'b0, 32'd5,        32'd0,        1, 32'd5,        32'hFFFFFFFF);

    // Flush in the middle of a divide: back to IDLE, no write ever appears.
    wes = 0;
    applyStimulus(1'b1, 1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1;
    checkOutput("flush done",  done_o,  32'd0);
    checkOutput("flush stall", stall_o, 32'd0);
    checkOutput("flush busy",  busy_o,  32'd1);
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0;
    #1;
    checkOutput("flush idle", busy_o, 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (hilo_we_o) wes++;
      @(negedge clk);
      #1;
    end
    checkOutput("flush writes", wes, 32'd0);

    // Asynchronous reset mid-divide clears outputs immediately (hi/lo hold 5/FFFFFFFF before).
    @(negedge clk);
    wes = 0;
    applyStimulus(1'b1, 1'b0, 32'd50, 32'd7);
    repeat (20) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid rst busy", busy_o, 32'd0);
    checkOutput("mid rst hi",   hi_o,   32'd0);
    checkOutput("mid rst lo",   lo_o,   32'd0);
    valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (hilo_we_o) wes++;
      @(negedge clk);
    end
    checkOutput("mid rst writes", wes, 32'd0);

    // External stall holds DONE for three cycles, then the write, then a back-to-back MULT.
    applyStimulus(1'b0, 1'b0, 32'd6, 32'd7);
    stall_i = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("hold done",  done_o,  32'd0);
      checkOutput("hold busy",  busy_o,  32'd1);
      checkOutput("hold stall", stall_o, 32'd1);
      checkOutput("hold lo",    lo_o,    32'd42);
      @(negedge clk);
    end
    stall_i = 1'b0;
    #1;
    checkOutput("release done", done_o,    32'd1);
    checkOutput("release we",   hilo_we_o, 32'd1);
    checkOutput("release hi",   hi_o,      32'd0);
    checkOutput("release lo",   lo_o,      32'd42);
    @(negedge clk);
    runOp("mult b2b", 1'b0, 1'b1, 32'hFFFFFFFE, 32'd3, 3, 32'hFFFFFFFF, 32'hFFFFFFFA);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Multi-cycle multiply/divide sequencer for the EX stage. It accepts MULT/MULTU/DIV/DIVU operations, runs a fixed-latency multiply and a 32-iteration radix-2 restoring divide, and stalls the pipeline until the result is ready. It then presents HI/LO with a one-cycle write enable to the HI/LO register file, and honours exception flushes and external pipeline stalls.

## Interface
- MUL_LAT, default 2: cycles spent in MUL state (≥1); product is formed at start and held.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- valid_i  in  1  EX holds a mult/div instruction (alucontrol is DIV_CONTROL or MULT_CONTROL); must stay high until the cycle after done_o.
- is_div_i  in  1  1 = divide, 0 = multiply.
- signed_i  in  1  1 = MULT/DIV, 0 = MULTU/DIVU.
- src_a_i  in  32  rs operand (dividend / multiplicand).
- src_b_i  in  32  rt operand (divisor / multiplier).
- flush_i  in  1  exception/flush; cancels any operation.
- stall_i  in  1  pipeline held by another source; result must wait.
- stall_o  out  1  request EX/earlier stages to hold.
- busy_o  out  1  state ≠ IDLE.
- done_o  out  1  result accepted this cycle (single-cycle pulse).
- hilo_we_o  out  1  write HI and LO this cycle (equals done_o).
- hi_o  out  32  HI value: product[63:32] or remainder.
- lo_o  out  32  LO value: product[31:0] or quotient.

## Operation
- States: IDLE, MUL, DIV, DONE; 6-bit cycle counter; 32-bit quotient/remainder/divisor registers; 64-bit product register; sign flags for quotient and remainder.
- IDLE: when valid_i & ~flush_i, latch operands and go to MUL (multiply), DIV (divide, b ≠ 0) or DONE (divide, b = 0).
- Multiply: product = signed_i ? signed 32×32 : unsigned 32×32, full 64-bit, registered at start. MUL counts MUL_LAT cycles, then goes to DONE.
- Divide: at start, store |a| and |b| when signed_i (raw values otherwise). Store qneg = sign(a)^sign(b) and rneg = sign(a), both only when signed_i. DIV runs exactly 32 iterations, one quotient bit per cycle, MSB first: shift remainder left by 1 and shift in the next dividend bit; if remainder ≥ divisor, subtract it and set the quotient bit. After 32 cycles go to DONE.
- DONE outputs: lo = qneg ? −q : q; hi = rneg ? −r : r (32-bit two's complement, wrap allowed). Signed 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- Divide by zero: no iterations, no exception; lo = 0xFFFFFFFF, hi = src_a_i as latched; no sign correction.
- DONE with stall_i = 1: hold the state and results, done_o = 0. DONE with stall_i = 0: done_o = hilo_we_o = 1, then go to IDLE.
- flush_i in any state: next state is IDLE, done_o/hilo_we_o are forced to 0 in that cycle, and no HI/LO write ever occurs for the cancelled op.
- stall_o = valid_i & ~flush_i & ~(state == DONE & ~stall_i). It is high from the start cycle through the last compute cycle.

## Timing
- Reset: state IDLE, counter 0, hi_o = lo_o = 0, done_o = hilo_we_o = 0, busy_o = 0. stall_o is 0 while valid_i = 0.
- Multiply: start cycle T0 (IDLE), MUL at T1..T(MUL_LAT), DONE at T(MUL_LAT+1). That is 1+MUL_LAT stall cycles; the result writes at T(MUL_LAT+1) if stall_i = 0.
- Divide (b ≠ 0): T0 start, DIV at T1..T32, DONE at T33. That is 33 stall cycles; the write happens at T33.
- Divide by zero: T0 start, DONE at T1.
- Back-to-back: DONE→IDLE takes one cycle, then the new op is sampled in IDLE. Minimum spacing between writes is MUL_LAT+2 (multiply) or 34 (divide).
- hi_o/lo_o are valid whenever state = DONE. They are registered, with no combinational path from src_*_i.
- Reset asserted mid-operation: IDLE immediately (asynchronous), no write.
- flush_i and stall_i both high in DONE: flush wins.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, MUL_LAT = 2 -> stall_o high 3 cycles; hi = 0xFFFFFFFE, lo = 0x00000001, hilo_we_o pulses once.
- MULT −3 × 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- DIV −7 / 2 -> 33 stall cycles; lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 7 / 2 -> lo = 3, hi = 1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0. DIVU 5 / 0 -> DONE after 1 cycle; lo = 0xFFFFFFFF, hi = 5.
- Start a divide, assert flush_i at T10 -> IDLE at T11, no hilo_we_o, stall_o low. Assert rst at T20 of another divide -> immediate IDLE, outputs zero.
- stall_i high for 3 cycles in DONE -> results held, done_o low; done_o pulses on the first cycle stall_i is low. A following MULT starts in the next IDLE cycle.
